// File: rtl/vec_alu_pkg.sv
// Shared types and helpers for the vector reduction ALU.
package vec_alu_pkg;

  localparam int unsigned MAX_BITS = 64;

  typedef enum logic [1:0] {
    RED_ADD = 2'b00,
    RED_MAX = 2'b01,
    RED_MIN = 2'b10,
    RED_XOR = 2'b11
  } reduce_op_t;

  // Identity at full width; callers truncate to their element width.
  function automatic logic [MAX_BITS-1:0] red_identity(input reduce_op_t op);
    return (op == RED_MIN) ? {MAX_BITS{1'b1}} : {MAX_BITS{1'b0}};
  endfunction

endpackage

// File: rtl/reduce_op_unit.sv
// Combinational two-operand reduction step: ADD (wrapping), unsigned MAX/MIN, XOR.
module reduce_op_unit
  import vec_alu_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  reduce_op_t      op,
  output logic [BITS-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      RED_ADD: y = a + b;
      RED_MAX: y = (a >= b) ? a : b;
      RED_MIN: y = (a <= b) ? a : b;
      RED_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/reduce_vector_alu.sv
// Snapshots a vector on set and folds its first in_len elements, one per enabled clock.
module reduce_vector_alu
  import vec_alu_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   set,
  input  logic [BITS-1:0]        in [N-1:0],
  input  logic [$clog2(N+1)-1:0] in_len,
  input  logic [1:0]             sel,
  output logic [BITS-1:0]        out,
  output logic                   done
);

  localparam int unsigned LW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [BITS-1:0] vec [N-1:0];
  reduce_op_t      op;
  logic [LW-1:0]   len;
  logic [LW-1:0]   idx;
  logic [BITS-1:0] acc;
  logic [BITS-1:0] y;
  logic [BITS-1:0] ident;
  logic [BITS-1:0] elem;
  logic [LW-1:0]   len_clamped;
  logic [LW-1:0]   idx_next;
  logic            start;

  assign len_clamped = (in_len > LW'(N)) ? LW'(N) : in_len;
  assign ident       = BITS'(red_identity(reduce_op_t'(sel)));
  assign elem        = vec[idx[IW-1:0]];
  assign idx_next    = idx + LW'(1);
  assign start       = en && set && (state == IDLE);

  reduce_op_unit #(.BITS(BITS)) u_op (
    .a  (acc),
    .b  (elem),
    .op (op),
    .y  (y)
  );

  // Operand snapshot; contents are don't-care until the first start.
  always_ff @(posedge clk) begin
    if (start) vec <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      done  <= 1'b0;
      idx   <= '0;
      acc   <= '0;
      len   <= '0;
      op    <= RED_ADD;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (set) begin
            op  <= reduce_op_t'(sel);
            len <= len_clamped;
            idx <= '0;
            acc <= ident;
            // Zero-length reductions complete on the start edge itself.
            if (len_clamped == '0) begin
              out  <= ident;
              done <= 1'b1;
            end else begin
              done  <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= y;
          idx <= idx_next;
          if (idx_next == len) begin
            out   <= y;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_vector_alu.sv
// Self-checking bench for reduce_vector_alu against a plain-arithmetic reference model.
module tb_reduce_vector_alu;

  localparam int BITS = 8;
  localparam int N    = 8;

  typedef logic [BITS-1:0] vec_t [N-1:0];

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        set;
  vec_t        vin;
  logic [3:0]  in_len;
  logic [1:0]  sel;
  logic [7:0]  out;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reduce_vector_alu #(.BITS(BITS), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .set    (set),
    .in     (vin),
    .in_len (in_len),
    .sel    (sel),
    .out    (out),
    .done   (done)
  );

  function automatic logic [7:0] model(input vec_t v, input int len, input logic [1:0] op);
    int acc;
    int n;
    n   = (len > N) ? N : len;
    acc = (op == 2'b10) ? 255 : 0;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00: acc = (acc + int'(v[i])) % 256;
        2'b01: if (int'(v[i]) > acc) acc = int'(v[i]);
        2'b10: if (int'(v[i]) < acc) acc = int'(v[i]);
        default: acc = acc ^ int'(v[i]);
      endcase
    end
    return 8'(acc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) vin[i] = 8'($urandom_range(0, 255));
    in_len = 4'($urandom_range(0, 15));
    sel    = 2'($urandom_range(0, 3));
  endtask

  // Start a reduction, optionally stall and disturb inputs, then check latency and result.
  task automatic run(input string name, input vec_t v, input int len, input logic [1:0] op,
                     input bit stall, input bit scramble, input logic [7:0] exp);
    int eff;
    int en_edges;
    int cyc;
    logic [7:0] held;
    eff    = (len > N) ? N : len;
    vin    = v;
    in_len = 4'(len);
    sel    = op;
    en     = 1'b1;
    set    = 1'b1;
    tick();
    set = 1'b0;
    if (eff > 0) begin
      n_cmp++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_after_start: got %b want 0", name, done);
      end
    end
    en_edges = 0;
    cyc      = 0;
    while (done !== 1'b1 && cyc < 200) begin
      en = (stall && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if (scramble) begin
        randomize_inputs();
        set = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
      if (en) en_edges++;
    end
    en  = 1'b1;
    set = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: done never rose within 200 cycles", name);
    end
    n_cmp++;
    if (en_edges != eff) begin
      n_fail++;
      $display("FAIL %s latency: got %0d enabled edges want %0d", name, en_edges, eff);
    end
    n_cmp++;
    if (out !== exp) begin
      n_fail++;
      $display("FAIL %s out: got %h want %h", name, out, exp);
    end
    held = out;
    randomize_inputs();
    tick();
    tick();
    n_cmp++;
    if (out !== held || done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s hold: got out=%h done=%b want out=%h done=1", name, out, done, held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; set = 1'b0; in_len = '0; sel = '0;
    for (int i = 0; i < N; i++) vin[i] = '0;
    tick();
    tick();
    n_cmp++;
    if (out !== 8'h00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%h done=%b want out=00 done=0", out, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 255));
    v[0] = 8'h03; v[1] = 8'h12; v[2] = 8'h40; v[3] = 8'h04;
    run("max",  v, 4, 2'b01, 1'b0, 1'b0, 8'h40);
    run("add",  v, 4, 2'b00, 1'b0, 1'b0, 8'h59);
    run("xor",  v, 4, 2'b11, 1'b0, 1'b0, 8'h55);
    run("min",  v, 4, 2'b10, 1'b0, 1'b0, 8'h03);
  endtask

  task automatic test_boundaries();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 8'hFF;
    run("add_wrap", v, 8, 2'b00, 1'b0, 1'b0, 8'hF8);
    run("zero_len_min", v, 0, 2'b10, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < N; i++) v[i] = 8'(i + 1);
    run("len_clamp", v, 13, 2'b00, 1'b0, 1'b0, 8'd36);
  endtask

  task automatic test_stall_ignore();
    vec_t v;
    int edges;
    for (int i = 0; i < N; i++) v[i] = 8'(16 * i + 5);
    vin = v; in_len = 4'd4; sel = 2'b00; en = 1'b1; set = 1'b1;
    tick();
    set   = 1'b0;
    edges = 0;
    tick(); edges++;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        for (int i = 0; i < N; i++) vin[i] = 8'hAA;
        set = 1'b1;
      end else begin
        set = 1'b0;
      end
      tick(); edges++;
    end
    en = 1'b1; set = 1'b1; sel = 2'b01;
    tick(); edges++;
    set = 1'b0;
    while (done !== 1'b1 && edges < 50) begin
      tick(); edges++;
    end
    n_cmp++;
    if (edges != 7) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d edges want 7", edges);
    end
    n_cmp++;
    if (out !== model(v, 4, 2'b00)) begin
      n_fail++;
      $display("FAIL stall_out: got %h want %h", out, model(v, 4, 2'b00));
    end
  endtask

  task automatic test_abort_reset();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = 8'(i + 7);
    vin = v; in_len = 4'd6; sel = 2'b00; en = 1'b1; set = 1'b1;
    tick();
    set = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out !== 8'h00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got out=%h done=%b want out=00 done=0", out, done);
    end
    for (int k = 0; k < 10; k++) begin
      randomize_inputs();
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done: got done=%b want 0 at cycle %0d", done, k);
      end
    end
  endtask

  task automatic test_random();
    vec_t v;
    int len;
    logic [1:0] op;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 15);
      op  = 2'($urandom_range(0, 3));
      run($sformatf("rand%0d", t), v, len, op, 1'b1, 1'b1, model(v, len, op));
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 255));
      run($sformatf("b2b%0d", t), v, 1 + t, 2'(t), 1'b0, 1'b0, model(v, 1 + t, 2'(t)));
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_boundaries();
    test_stall_ignore();
    test_abort_reset();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
